// File: rtl/mult_8x8_seq_div.sv
// ============================================================================
// mult_8x8_seq_div
// ----------------------------------------------------------------------------
// Sequential restoring divider, the inverse of the 8x8 multiplier family.
// A 16-bit product-format dividend N is divided by an 8-bit factor D. The
// result is the 8-bit cofactor (quotient Q) and the 8-bit remainder Rm.
// One quotient bit is resolved per clock while in CALC.
//
// Results whose quotient cannot fit in 8 bits (N[15:8] >= D) raise OVF.
// Division by zero raises DZ. Both take a one-edge shortcut to DONE.
//
// Optional feature: macro MULT_DIV_SAT_EN
//   defined   : OVF/DZ results saturate to Q = 8'hFF, Rm = N[7:0]
//   undefined : OVF/DZ results return Q = 0, Rm = 0
//   The normal path is identical in both builds.
//
// Ports
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   in_valid   in   1   N and D are valid
//   in_ready   out  1   divider is idle and can accept an operation
//   N          in   16  dividend (product format)
//   D          in   8   divisor (multiplier factor)
//   out_valid  out  1   result is valid, held until out_ready
//   out_ready  in   1   consumer accepts the result
//   Q          out  8   quotient
//   Rm         out  8   remainder
//   OVF        out  1   quotient overflow (N[15:8] >= D, D != 0)
//   DZ         out  1   divisor is zero
// ============================================================================
module mult_8x8_seq_div #(
    parameter int unsigned ITER = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] N,
    input  logic [7:0]  D,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  Q,
    output logic [7:0]  Rm,
    output logic        OVF,
    output logic        DZ
);

    localparam int unsigned CW = $clog2(ITER);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q;
    logic [7:0]    d_q;
    logic [7:0]    rem_q;
    logic [7:0]    sh_q;
    logic [7:0]    quo_q;
    logic [CW-1:0] cnt_q;
    logic [7:0]    q_q;
    logic [7:0]    rm_q;
    logic          ovf_q;
    logic          dz_q;
    logic          out_valid_q;
    logic          in_ready_q;

    // Restoring step datapath
    logic [8:0]    ext_d;
    logic [9:0]    trial_d;
    logic          neg_d;
    logic [7:0]    rem_d;
    logic [7:0]    quo_d;

    always_comb begin
        ext_d   = {rem_q, sh_q[7]};
        trial_d = {1'b0, ext_d} - {2'b00, d_q};
        // Since rem_q < d_q, a non-negative trial is always below d_q and
        // therefore below 256, so bits [9:8] are both zero exactly when the
        // subtraction did not borrow.
        neg_d   = |trial_d[9:8];
        if (neg_d) begin
            rem_d = ext_d[7:0];
        end else begin
            rem_d = trial_d[7:0];
        end
        quo_d = {quo_q[6:0], ~neg_d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            d_q         <= '0;
            rem_q       <= '0;
            sh_q        <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            q_q         <= '0;
            rm_q        <= '0;
            ovf_q       <= 1'b0;
            dz_q        <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        d_q        <= D;
                        in_ready_q <= 1'b0;
                        if (D == 8'h00) begin
                            dz_q        <= 1'b1;
                            out_valid_q <= 1'b1;
`ifdef MULT_DIV_SAT_EN
                            q_q         <= 8'hFF;
                            rm_q        <= N[7:0];
`else
                            q_q         <= '0;
                            rm_q        <= '0;
`endif
                            state_q     <= DONE;
                        end else if (N[15:8] >= D) begin
                            ovf_q       <= 1'b1;
                            out_valid_q <= 1'b1;
`ifdef MULT_DIV_SAT_EN
                            q_q         <= 8'hFF;
                            rm_q        <= N[7:0];
`else
                            q_q         <= '0;
                            rm_q        <= '0;
`endif
                            state_q     <= DONE;
                        end else begin
                            rem_q   <= N[15:8];
                            sh_q    <= N[7:0];
                            quo_q   <= '0;
                            cnt_q   <= '0;
                            state_q <= CALC;
                        end
                    end
                end

                CALC: begin
                    rem_q <= rem_d;
                    sh_q  <= {sh_q[6:0], 1'b0};
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        q_q         <= quo_d;
                        rm_q        <= rem_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end

                DONE: begin
                    // Q and Rm keep their last value after the handshake.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        ovf_q       <= 1'b0;
                        dz_q        <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end

                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign Q         = q_q;
    assign Rm        = rm_q;
    assign OVF       = ovf_q;
    assign DZ        = dz_q;

endmodule
